// File: rtl/exmem_pkg.sv
// Shared types and default widths for the EX/MEM pipeline register.
package exmem_pkg;

  localparam int EXMEM_DATA_W     = 16;
  localparam int EXMEM_REG_ADDR_W = 3;

  typedef struct packed {
    logic wb;
    logic wmem;
    logic load;
  } exmem_ctrl_t;

  localparam exmem_ctrl_t EXMEM_CTRL_NOP = '{wb: 1'b0, wmem: 1'b0, load: 1'b0};

endpackage

// File: rtl/exmem_sat_counter.sv
// Saturating up-counter with asynchronous clear; sticks at all-ones.
module exmem_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid bit, stall/flush and forwarding outputs.
// Optional stall/flush performance counters are enabled by EXMEM_PERF_CNT_EN.
module exmem_pipe_reg
  import exmem_pkg::*;
#(
  parameter int DATA_W       = EXMEM_DATA_W,
  parameter int REG_ADDR_W   = EXMEM_REG_ADDR_W,
  parameter bit R0_HARDWIRED = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_in,
  input  logic                  wmem_in,
  input  logic                  load_in,
  input  logic [DATA_W-1:0]     result_in,
  input  logic [DATA_W-1:0]     wdmem_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  valid_out,
  output logic                  wb_out,
  output logic                  wmem_out,
  output logic                  load_out,
  output logic [DATA_W-1:0]     result_out,
  output logic [DATA_W-1:0]     wdmem_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  fwd_en,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("exmem_pipe_reg: CNT_W must be at least 1");
  end

  logic                  valid_q, valid_d;
  exmem_ctrl_t           ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic [DATA_W-1:0]     wdmem_q, wdmem_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  // NOTE: every always_comb output takes its hold value first, so no path can infer a latch.
  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    wdmem_d  = wdmem_q;
    rd_d     = rd_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = EXMEM_CTRL_NOP;
    end else if (!stall) begin
      valid_d     = valid_in;
      ctrl_d.wb   = wb_in   & valid_in;
      ctrl_d.wmem = wmem_in & valid_in;
      ctrl_d.load = load_in & valid_in;
      result_d    = result_in;
      wdmem_d     = wdmem_in;
      rd_d        = rd_in;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= EXMEM_CTRL_NOP;
      result_q <= '0;
      wdmem_q  <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      wdmem_q  <= wdmem_d;
      rd_q     <= rd_d;
    end
  end

  assign valid_out  = valid_q;
  assign wb_out     = ctrl_q.wb;
  assign wmem_out   = ctrl_q.wmem;
  assign load_out   = ctrl_q.load;
  assign result_out = result_q;
  assign wdmem_out  = wdmem_q;
  assign rd_out     = rd_q;

  // Load data only exists after the memory stage, so loads never forward from here.
  logic rd_is_r0;
  assign rd_is_r0 = R0_HARDWIRED && (rd_q == '0);
  assign fwd_en   = valid_q & ctrl_q.wb & ~ctrl_q.load & ~rd_is_r0;
  assign fwd_rd   = rd_q;
  assign fwd_data = result_q;

`ifdef EXMEM_PERF_CNT_EN
  exmem_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall & ~flush),
    .count (stall_cnt)
  );

  exmem_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush & valid_q),
    .count (flush_cnt)
  );
`endif

  a_bubble_ctrl_zero : assert property (
    @(posedge clk) disable iff (!rst_n) !valid_q |-> (ctrl_q == EXMEM_CTRL_NOP)
  ) else $error("control bits set on an empty stage");

endmodule

// File: doc/exmem_pipe_reg.md
Name: exmem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register for the MIPS simulator core. Successor to the plain clocked EX/MEM latch. Adds:
- asynchronous reset
- a per-stage valid bit
- stall (hold) and flush (squash) control
- registered forwarding outputs for the EX operand muxes

Sits between the ALU stage and the data-memory stage.

Parameters:
DATA_W, 16, width of ALU result and store-data paths
REG_ADDR_W, 3, width of destination register index
R0_HARDWIRED, 1, when 1 register index 0 is never a forwarding source
CNT_W, 16, width of performance counters (used only with EXMEM_PERF_CNT_EN)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
stall  in  1  hold all stage contents this cycle
flush  in  1  squash stage contents (insert bubble)
valid_in  in  1  EX stage holds a real instruction
wb_in  in  1  register write-back enable
wmem_in  in  1  data-memory write enable
load_in  in  1  instruction is a load
result_in  in  DATA_W  ALU result / memory address
wdmem_in  in  DATA_W  store data
rd_in  in  REG_ADDR_W  destination register index
valid_out  out  1  stage holds a real instruction
wb_out  out  1  registered wb, gated by valid
wmem_out  out  1  registered wmem, gated by valid
load_out  out  1  registered load, gated by valid
result_out  out  DATA_W  registered result
wdmem_out  out  DATA_W  registered store data
rd_out  out  REG_ADDR_W  registered destination index
fwd_en  out  1  result_out is a legal forwarding source
fwd_rd  out  REG_ADDR_W  forwarding register index (= rd_out)
fwd_data  out  DATA_W  forwarding data (= result_out)

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): all registered outputs are 0, including valid_out, controls, result_out, wdmem_out and rd_out. fwd_en is therefore 0.
- Latency: 1 cycle from inputs to outputs. No combinational path from inputs to outputs.
- Per rising edge, priority order: flush > stall > load.
- flush=1: valid_out, wb_out, wmem_out and load_out are all set to 0. result_out, wdmem_out and rd_out hold. Flush wins even if stall=1.
- stall=1, flush=0: every register holds its value.
- Neither asserted:
  - valid_out <= valid_in.
  - wb_out <= wb_in & valid_in; wmem_out and load_out follow the same rule.
  - result_out, wdmem_out and rd_out load unconditionally, whether or not valid_in is set.
- Invariant, checked by assertion: when valid_out=0, wb_out, wmem_out and load_out are all 0.
- Forwarding (combinational from registers only):
  - fwd_en = valid_out & wb_out & ~load_out & ~(R0_HARDWIRED & (rd_out==0)).
  - Loads never forward from this stage; load data is not yet available.
  - fwd_rd = rd_out; fwd_data = result_out.
- Reset deasserted mid-stall: the first edge after release obeys stall. The stage stays empty until a non-stalled load.

Optional Feature:
Macro EXMEM_PERF_CNT_EN.
- Defined: adds outputs stall_cnt [CNT_W] and flush_cnt [CNT_W].
  - stall_cnt increments on every edge where stall=1 and flush=0.
  - flush_cnt increments on every edge where flush=1 and valid_out was 1 (a real instruction was squashed).
  - Both counters saturate at all-ones and clear on rst_n=0.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package exmem_pkg holds:
  - DATA_W and REG_ADDR_W defaults
  - a packed struct typedef exmem_ctrl_t {wb, wmem, load}
  - constant EXMEM_CTRL_NOP = all zeros
- Natural sub-module: exmem_sat_counter, a CNT_W saturating counter with inc and async clear. It is instantiated twice under EXMEM_PERF_CNT_EN.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with outputs populated → all outputs 0 immediately, before the next clk edge; fwd_en=0.
- Normal flow: valid_in=1, wb_in=1, rd_in=3, result_in=16'h1234 → next edge valid_out=1, rd_out=3, fwd_en=1, fwd_data=16'h1234.
- Stall hold: stall=1 for 3 cycles while inputs change → outputs frozen at prior values. With perf counters enabled, stall_cnt=3.
- Flush priority: stall=1 and flush=1 together → valid_out=0, wb_out=0, wmem_out=0, load_out=0, result_out unchanged. flush_cnt increments by 1 only if valid_out was 1.
- Forwarding suppression:
  - load_in=1, wb_in=1, rd_in=5 → fwd_en=0.
  - wb_in=1, rd_in=0 with R0_HARDWIRED=1 → fwd_en=0.
  - same rd_in=0 with R0_HARDWIRED=0 → fwd_en=1.
- Bubble gating: valid_in=0 with wb_in=1, wmem_in=1 → valid_out=0 and all controls 0. result_out still loads result_in.
